mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle control sequencer for the 5-bit-opcode datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. It handles handshakes with instruction memory, data memory and a multi-cycle ALU, and produces per-cycle datapath control (reg_write, mem_read, mem_write, mem_reg, alu_src, alu_op, pc_nxt). It replaces single-cycle decoding when memories and the ALU have variable latency.

## Interface
- WAIT_MAX, 255: maximum cycles spent in any wait state before the block traps (1..255).
- TW, 8: width of the wait counter.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bc  in  2  instruction class from IR: 00 ALU, 01 memory, 10 control flow, 11 halt.
- ct  in  1  sub-class: memory 0=load/1=store; control flow 0=branch/1=jump.
- opcode  in  5  ALU opcode from IR.
- imem_ready  in  1  instruction word valid.
- dmem_ready  in  1  data access complete.
- alu_done  in  1  multi-cycle ALU result valid.
- zero  in  1  ALU zero flag.
- imem_req  out  1  instruction fetch request.
- ir_load, pc_write  out  1  IR load strobe and PC write strobe.
- pc_nxt  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target, 11 trap vector.
- reg_write, mem_read, mem_write, mem_reg, alu_src  out  1  datapath controls.
- alu_op  out  5  ALU operation.
- alu_start  out  1  one-cycle start pulse for the multi-cycle ALU.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  one-cycle pulse on entry to TRAP.
- halted  out  1  high while in HALT.
- state  out  3  current state, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, ALU_WAIT=3, MEM=4, WB=5, HALT=6, TRAP=7.
- Outputs are decoded from the state register and the latched fields. Any output not listed for a state is 0.
- FETCH: imem_req=1. When imem_ready=1, assert ir_load=1, pc_write=1 and pc_nxt=00, then go to DECODE.
- DECODE: latch bc, ct and opcode into internal registers, then classify:
  - bc=11 goes to HALT.
  - bc=00 with opcode in {01101, 10011..11111} is illegal and goes to TRAP.
  - All other instructions go to EXEC.
- EXEC, ALU class: alu_src=0 and alu_op = latched opcode.
  - Opcodes 01001..01100 are multi-cycle: assert alu_start=1 and go to ALU_WAIT.
  - All other ALU opcodes go to WB.
- EXEC, load/store: alu_src=1, alu_op=00001 (address add), then go to MEM.
- EXEC, branch: alu_op=00010 (subtract). If zero=1, assert pc_write=1 with pc_nxt=01. Then go to FETCH with retire=1.
- EXEC, jump: pc_write=1, pc_nxt=10, retire=1, then go to FETCH.
- ALU_WAIT: alu_op is held. On alu_done=1 go to WB.
- MEM, load: mem_read=1 until dmem_ready=1, then go to WB.
- MEM, store: mem_write=1 until dmem_ready=1, then assert retire=1 and go to FETCH.
- WB: reg_write=1 and retire=1. mem_reg=1 for a load, 0 for an ALU op. Then go to FETCH.
- HALT: halted=1. HALT is sticky; only reset leaves it.
- TRAP: illegal=1, pc_write=1, pc_nxt=11, then go to FETCH. No retire.
- Wait counter:
  - It counts cycles spent in FETCH, MEM or ALU_WAIT and clears on every state change.
  - When the count reaches WAIT_MAX with the handshake still low, the next state is TRAP.
  - If the handshake and the count limit occur in the same cycle, the handshake wins.

## Timing
- Reset:
  - While rst=1: state=FETCH, latched fields=0, counter=0, and every output is 0 (imem_req is gated by rst).
  - imem_req first rises in the cycle after rst falls.
  - Asserting rst in any state aborts the current instruction immediately; no strobe completes.
- Best-case latency, from imem_ready to retire:
  - Single-cycle ALU op: 3 cycles (FETCH→DECODE→EXEC→WB).
  - Jump/branch: 2 cycles.
  - Load with dmem_ready in the first MEM cycle: 4 cycles.
  - Store: 3 cycles.
- alu_done is sampled only in ALU_WAIT. If alu_done is already high during EXEC, it is ignored, and ALU_WAIT still lasts at least one cycle.
- imem_ready is ignored outside FETCH. dmem_ready is ignored outside MEM.
- IR fields must be stable from the ir_load cycle through DECODE; they are not sampled after DECODE.
- Handshake inputs held high give back-to-back completion, with no bubble beyond the states listed.

## Test plan
- Reset and fetch: hold rst for 3 cycles with imem_ready=1 → all outputs 0 during reset. The first cycle after release has imem_req=1, ir_load=1, pc_write=1, pc_nxt=00.
- ALU op: bc=00, opcode=00011 → DECODE, then EXEC with alu_op=00011, then WB with reg_write=1, mem_reg=0, retire=1. Back in FETCH 3 cycles after DECODE.
- Multi-cycle ALU: opcode=01010, alu_done asserted 5 cycles after alu_start → one alu_start pulse. alu_op=01010 is held through ALU_WAIT. WB follows in the cycle after alu_done.
- Load with wait: bc=01, ct=0, dmem_ready delayed 4 cycles → mem_read=1 for 5 cycles, then WB with mem_reg=1, reg_write=1. Repeat as a store: mem_write held, then retire with no WB.
- Branch/jump: branch with zero=1 → pc_write=1, pc_nxt=01. Branch with zero=0 → pc_write=0 and retire=1. Jump → pc_nxt=10.
- Faults:
  - opcode=11000 → TRAP: illegal=1, pc_nxt=11.
  - WAIT_MAX=4 with imem_ready stuck low → TRAP after 4 FETCH cycles.
  - bc=11 → halted=1 held for 20 cycles until rst.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the datapath,
// memories and multi-cycle ALU.
interface mc_ctrl_fsm_if;
  logic [1:0] bc;
  logic       ct;
  logic [4:0] opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       alu_done;
  logic       zero;
  logic       imem_req;
  logic       ir_load;
  logic       pc_write;
  logic [1:0] pc_nxt;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_reg;
  logic       alu_src;
  logic [4:0] alu_op;
  logic       alu_start;
  logic       retire;
  logic       illegal;
  logic       halted;
  logic [2:0] state;

  modport master (
    input  bc, ct, opcode,
    input  imem_ready, dmem_ready, alu_done, zero,
    output imem_req, ir_load, pc_write, pc_nxt,
    output reg_write, mem_read, mem_write, mem_reg,
    output alu_src, alu_op, alu_start,
    output retire, illegal, halted, state
  );

  modport slave (
    output bc, ct, opcode,
    output imem_ready, dmem_ready, alu_done, zero,
    input  imem_req, ir_load, pc_write, pc_nxt,
    input  reg_write, mem_read, mem_write, mem_reg,
    input  alu_src, alu_op, alu_start,
    input  retire, illegal, halted, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with
// per-state wait watchdog, trap and sticky halt.
module mc_ctrl_fsm #(
  parameter int WAIT_MAX = 255,
  parameter int TW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  mc_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_ALU_WAIT = 3'd3,
    S_MEM      = 3'd4,
    S_WB       = 3'd5,
    S_HALT     = 3'd6,
    S_TRAP     = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [1:0]    r_bc;
  logic          r_ct;
  logic [4:0]    r_op;
  logic [TW-1:0] r_cnt;

  logic       w_ill;
  logic       w_multi;
  logic       w_limit;
  logic       w_wait;
  logic       w_imem_req;
  logic       w_ir_load;
  logic       w_pc_write;
  logic [1:0] w_pc_nxt;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_mem_reg;
  logic       w_alu_src;
  logic [4:0] w_alu_op;
  logic       w_alu_start;
  logic       w_retire;
  logic       w_illegal;
  logic       w_halted;

  assign w_ill   = (bus.opcode == 5'b01101) ||
                   (bus.opcode >= 5'b10011);
  assign w_multi = (r_op >= 5'b01001) &&
                   (r_op <= 5'b01100);
  // count holds cycles already spent, so the limit hits on cycle WAIT_MAX
  assign w_limit = (r_cnt >= TW'(WAIT_MAX - 1));
  assign w_wait  = (r_state == S_FETCH) ||
                   (r_state == S_MEM) ||
                   (r_state == S_ALU_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_bc    <= '0;
      r_ct    <= 1'b0;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_DECODE) begin
        r_bc <= bus.bc;
        r_ct <= bus.ct;
        r_op <= bus.opcode;
      end
      if (w_wait && (w_nxt == r_state))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    w_nxt       = r_state;
    w_imem_req  = 1'b0;
    w_ir_load   = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_nxt    = 2'b00;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_reg   = 1'b0;
    w_alu_src   = 1'b0;
    w_alu_op    = 5'b00000;
    w_alu_start = 1'b0;
    w_retire    = 1'b0;
    w_illegal   = 1'b0;
    w_halted    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ir_load  = 1'b1;
          w_pc_write = 1'b1;
          w_nxt      = S_DECODE;
        end else if (w_limit) begin
          w_nxt = S_TRAP;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (bus.bc == 2'b11):
            w_nxt = S_HALT;
          (bus.bc == 2'b00) && w_ill:
            w_nxt = S_TRAP;
          default:
            w_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        unique case (r_bc)
          2'b00: begin
            w_alu_op = r_op;
            if (w_multi) begin
              w_alu_start = 1'b1;
              w_nxt       = S_ALU_WAIT;
            end else begin
              w_nxt = S_WB;
            end
          end
          2'b01: begin
            w_alu_src = 1'b1;
            w_alu_op  = 5'b00001;
            w_nxt     = S_MEM;
          end
          2'b10: begin
            if (!r_ct) begin
              w_alu_op   = 5'b00010;
              w_pc_write = bus.zero;
              w_pc_nxt   = {1'b0, bus.zero};
            end else begin
              w_pc_write = 1'b1;
              w_pc_nxt   = 2'b10;
            end
            w_retire = 1'b1;
            w_nxt    = S_FETCH;
          end
          default: w_nxt = S_FETCH;
        endcase
      end
      S_ALU_WAIT: begin
        w_alu_op = r_op;
        if (bus.alu_done)
          w_nxt = S_WB;
        else if (w_limit)
          w_nxt = S_TRAP;
      end
      S_MEM: begin
        w_mem_write = r_ct;
        w_mem_read  = !r_ct;
        if (bus.dmem_ready) begin
          w_retire = r_ct;
          w_nxt    = r_ct ? S_FETCH : S_WB;
        end else if (w_limit) begin
          w_nxt = S_TRAP;
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_mem_reg   = (r_bc == 2'b01) && !r_ct;
        w_nxt       = S_FETCH;
      end
      S_HALT: w_halted = 1'b1;
      S_TRAP: begin
        w_illegal  = 1'b1;
        w_pc_write = 1'b1;
        w_pc_nxt   = 2'b11;
        w_nxt      = S_FETCH;
      end
    endcase
  end

  // reset must silence even the input-dependent strobes
  assign bus.imem_req  = w_imem_req  & ~rst;
  assign bus.ir_load   = w_ir_load   & ~rst;
  assign bus.pc_write  = w_pc_write  & ~rst;
  assign bus.pc_nxt    = w_pc_nxt    & {2{~rst}};
  assign bus.reg_write = w_reg_write & ~rst;
  assign bus.mem_read  = w_mem_read  & ~rst;
  assign bus.mem_write = w_mem_write & ~rst;
  assign bus.mem_reg   = w_mem_reg   & ~rst;
  assign bus.alu_src   = w_alu_src   & ~rst;
  assign bus.alu_op    = w_alu_op    & {5{~rst}};
  assign bus.alu_start = w_alu_start & ~rst;
  assign bus.retire    = w_retire    & ~rst;
  assign bus.illegal   = w_illegal   & ~rst;
  assign bus.halted    = w_halted    & ~rst;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: instruction-level generator builds per-cycle
// stimulus and expected outputs; one process compares every cycle.
module tb_mc_ctrl_fsm;
  localparam int WM = 5;

  typedef struct packed {
    logic       rst;
    logic [1:0] bc;
    logic       ct;
    logic [4:0] opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       alu_done;
    logic       zero;
  } in_t;

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_nxt;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_reg;
    logic       alu_src;
    logic [4:0] alu_op;
    logic       alu_start;
    logic       retire;
    logic       illegal;
    logic       halted;
    logic [2:0] state;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string tag;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mc_ctrl_fsm_if bus();

  mc_ctrl_fsm #(.WAIT_MAX(WM), .TW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  cyc_t  q[$];
  int    n_chk = 0;
  int    n_err = 0;
  out_t  exp_o;
  out_t  act;
  string exp_tag;
  string cur_tag;
  bit    chk_on = 1'b0;
  int    cyc_no = 0;

  function automatic in_t rnd_in();
    in_t v;
    v.rst        = 1'b0;
    v.bc         = 2'($urandom);
    v.ct         = 1'($urandom);
    v.opcode     = 5'($urandom);
    v.imem_ready = 1'($urandom);
    v.dmem_ready = 1'($urandom);
    v.alu_done   = 1'($urandom);
    v.zero       = 1'($urandom);
    return v;
  endfunction

  function automatic out_t o0(logic [2:0] s);
    out_t o;
    o       = '0;
    o.state = s;
    return o;
  endfunction

  function automatic bit is_ill(logic [4:0] op);
    return (op == 5'd13) || (op >= 5'd19);
  endfunction

  function automatic bit is_multi(logic [4:0] op);
    return (op >= 5'd9) && (op <= 5'd12);
  endfunction

  task automatic push(in_t i, out_t o);
    cyc_t c;
    c.i   = i;
    c.o   = o;
    c.tag = cur_tag;
    q.push_back(c);
  endtask

  task automatic p_trap();
    out_t o;
    o          = o0(3'd7);
    o.illegal  = 1'b1;
    o.pc_write = 1'b1;
    o.pc_nxt   = 2'b11;
    push(rnd_in(), o);
  endtask

  task automatic p_wb(bit ld);
    out_t o;
    o           = o0(3'd5);
    o.reg_write = 1'b1;
    o.retire    = 1'b1;
    o.mem_reg   = ld;
    push(rnd_in(), o);
  endtask

  task automatic p_reset(int n);
    for (int k = 0; k < n; k++) begin
      in_t i;
      i            = rnd_in();
      i.rst        = 1'b1;
      i.imem_ready = 1'b1;
      push(i, '0);
    end
  endtask

  // fetch lasts d+1 cycles; if that exceeds WM the watchdog traps
  task automatic p_fetch(int d, in_t f, output bit trap);
    int n;
    trap = (d >= WM);
    n    = trap ? WM : d + 1;
    for (int k = 1; k <= n; k++) begin
      in_t  i;
      out_t o;
      bit   last;
      last         = !trap && (k == n);
      i            = rnd_in();
      o            = o0(3'd0);
      i.imem_ready = last;
      o.imem_req   = 1'b1;
      if (last) begin
        i.bc       = f.bc;
        i.ct       = f.ct;
        i.opcode   = f.opcode;
        o.ir_load  = 1'b1;
        o.pc_write = 1'b1;
      end
      push(i, o);
    end
    if (trap) p_trap();
  endtask

  // kind: 0 multi-cycle ALU, 1 load, 2 store
  task automatic p_wait(int kind, int d, logic [4:0] op);
    bit trap;
    int n;
    trap = (d >= WM);
    n    = trap ? WM : d + 1;
    for (int k = 1; k <= n; k++) begin
      in_t  i;
      out_t o;
      bit   last;
      last = !trap && (k == n);
      i    = rnd_in();
      o    = o0(kind == 0 ? 3'd3 : 3'd4);
      if (kind == 0) begin
        i.alu_done = last;
        o.alu_op   = op;
      end else begin
        i.dmem_ready = last;
        o.mem_read   = (kind == 1);
        o.mem_write  = (kind == 2);
        o.retire     = last && (kind == 2);
      end
      push(i, o);
    end
    if (trap) p_trap();
    else if (kind != 2) p_wb(kind == 1);
  endtask

  task automatic p_halt(int n);
    for (int k = 0; k < n; k++) begin
      out_t o;
      o        = o0(3'd6);
      o.halted = 1'b1;
      push(rnd_in(), o);
    end
    p_reset(2);
  endtask

  // cls = instruction class bc; wd = wait delay (halt: cycles held)
  task automatic gen(int cls, int fd, int wd, logic [4:0] op,
                     logic z, logic c_t);
    in_t  f;
    in_t  i;
    out_t o;
    bit   tr;
    f    = rnd_in();
    f.bc = 2'(cls);
    f.ct = c_t;
    if (cls == 0) f.opcode = op;
    p_fetch(fd, f, tr);
    if (tr) return;
    i        = rnd_in();
    i.bc     = f.bc;
    i.ct     = f.ct;
    i.opcode = f.opcode;
    push(i, o0(3'd1));
    i = rnd_in();
    o = o0(3'd2);
    case (cls)
      0: begin
        if (is_ill(op)) begin
          p_trap();
        end else if (is_multi(op)) begin
          o.alu_op    = op;
          o.alu_start = 1'b1;
          push(i, o);
          p_wait(0, wd, op);
        end else begin
          o.alu_op = op;
          push(i, o);
          p_wb(1'b0);
        end
      end
      1: begin
        o.alu_src = 1'b1;
        o.alu_op  = 5'd1;
        push(i, o);
        p_wait(c_t ? 2 : 1, wd, 5'd0);
      end
      2: begin
        i.zero   = z;
        o.retire = 1'b1;
        if (!c_t) begin
          o.alu_op   = 5'd2;
          o.pc_write = z;
          o.pc_nxt   = z ? 2'b01 : 2'b00;
        end else begin
          o.pc_write = 1'b1;
          o.pc_nxt   = 2'b10;
        end
        push(i, o);
      end
      default: p_halt(wd);
    endcase
  endtask

  function automatic int cnt(int from, int what);
    int c;
    c = 0;
    for (int k = from; k < q.size(); k++) begin
      case (what)
        0: c += int'(q[k].o.alu_start);
        1: c += int'(q[k].o.state == 3'd3 && q[k].o.alu_op == 5'd10);
        2: c += int'(q[k].o.mem_read);
        3: c += int'(q[k].o.mem_write);
        4: c += int'(q[k].o.state == 3'd5);
        5: c += int'(q[k].o.state == 3'd0 && q[k].o.imem_req);
        default: c += int'(q[k].o.halted);
      endcase
    end
    return c;
  endfunction

  task automatic pin(string nm, int got, int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL pin %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      act = {bus.imem_req, bus.ir_load, bus.pc_write, bus.pc_nxt,
             bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_reg,
             bus.alu_src, bus.alu_op, bus.alu_start, bus.retire,
             bus.illegal, bus.halted, bus.state};
      n_chk++;
      if (act !== exp_o) begin
        n_err++;
        $display("FAIL %s cyc=%0d got=%h want=%h",
                 exp_tag, cyc_no, act, exp_o);
      end
    end
  end

  initial begin
    int   s;
    cyc_t l;
    bus.bc         = '0;
    bus.ct         = 1'b0;
    bus.opcode     = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.alu_done   = 1'b0;
    bus.zero       = 1'b0;

    cur_tag = "rst";
    p_reset(3);
    cur_tag = "alu";
    gen(0, 0, 0, 5'b00011, 1'b0, 1'b0);
    pin("alu_len", q.size(), 7);
    pin("fetch_strobe", int'({q[3].o.imem_req, q[3].o.ir_load,
        q[3].o.pc_write, q[3].o.pc_nxt}), 5'b11100);
    pin("alu_exec_op", int'(q[5].o.alu_op), 3);
    pin("alu_wb", int'({q[6].o.reg_write, q[6].o.mem_reg,
        q[6].o.retire, q[6].o.state}), 6'b101101);

    cur_tag = "mul";
    s = q.size();
    gen(0, 1, 4, 5'b01010, 1'b0, 1'b0);
    l = q[$];
    pin("mul_start", cnt(s, 0), 1);
    pin("mul_hold", cnt(s, 1), 5);
    pin("mul_wb", int'(l.o.state), 5);

    cur_tag = "ld";
    s = q.size();
    gen(1, 0, 4, 5'd0, 1'b0, 1'b0);
    l = q[$];
    pin("ld_read", cnt(s, 2), 5);
    pin("ld_wb", int'({l.o.mem_reg, l.o.reg_write}), 3);

    cur_tag = "st";
    s = q.size();
    gen(1, 0, 4, 5'd0, 1'b0, 1'b1);
    l = q[$];
    pin("st_write", cnt(s, 3), 5);
    pin("st_nowb", cnt(s, 4), 0);
    pin("st_retire", int'(l.o.retire), 1);

    cur_tag = "br";
    gen(2, 0, 0, 5'd0, 1'b1, 1'b0);
    l = q[$];
    pin("br_taken", int'({l.o.pc_write, l.o.pc_nxt, l.o.retire}), 4'b1011);
    gen(2, 0, 0, 5'd0, 1'b0, 1'b0);
    l = q[$];
    pin("br_not", int'({l.o.pc_write, l.o.pc_nxt, l.o.retire}), 4'b0001);
    cur_tag = "jmp";
    gen(2, 0, 0, 5'd0, 1'b0, 1'b1);
    l = q[$];
    pin("jump", int'({l.o.pc_write, l.o.pc_nxt, l.o.retire}), 4'b1101);

    cur_tag = "ill";
    gen(0, 0, 0, 5'b11000, 1'b0, 1'b0);
    l = q[$];
    pin("illegal", int'({l.o.illegal, l.o.pc_nxt, l.o.state}), 6'b111111);

    cur_tag = "tmo";
    s = q.size();
    gen(0, WM, 0, 5'd3, 1'b0, 1'b0);
    l = q[$];
    pin("tmo_fetch", cnt(s, 5), WM);
    pin("tmo_trap", int'(l.o.state), 7);

    cur_tag = "rnd";
    for (int n = 0; n < 300; n++) begin
      int r;
      int fd;
      int wd;
      logic [4:0] op;
      s  = q.size();
      r  = $urandom_range(0, 99);
      fd = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2)
                                      : $urandom_range(0, WM);
      wd = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2)
                                      : $urandom_range(0, WM);
      op = $urandom_range(0, 1) ? 5'($urandom)
                                : 5'($urandom_range(9, 12));
      if (r < 35)
        gen(0, fd, wd, op, 1'b0, 1'b0);
      else if (r < 60)
        gen(1, fd, wd, op, 1'b0, 1'($urandom));
      else if (r < 95)
        gen(2, fd, wd, op, 1'($urandom), 1'($urandom));
      else
        gen(3, fd, $urandom_range(1, 4), op, 1'b0, 1'b0);
      if ($urandom_range(0, 11) == 0 && q.size() - s > 1) begin
        repeat ($urandom_range(1, q.size() - s - 1))
          void'(q.pop_back());
        p_reset($urandom_range(1, 2));
      end
    end

    cur_tag = "halt";
    s = q.size();
    gen(3, 0, 20, 5'd0, 1'b0, 1'b0);
    pin("halt_hold", cnt(s, 6), 20);
    cur_tag = "post";
    gen(0, 0, 0, 5'd7, 1'b0, 1'b0);

    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      rst            = q[k].i.rst;
      bus.bc         = q[k].i.bc;
      bus.ct         = q[k].i.ct;
      bus.opcode     = q[k].i.opcode;
      bus.imem_ready = q[k].i.imem_ready;
      bus.dmem_ready = q[k].i.dmem_ready;
      bus.alu_done   = q[k].i.alu_done;
      bus.zero       = q[k].i.zero;
      exp_o          = q[k].o;
      exp_tag        = q[k].tag;
      cyc_no         = k;
      chk_on         = 1'b1;
    end
    @(negedge clk);
    chk_on = 1'b0;
    #4;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
